// File: rtl/instr_issue_pkg.sv
// Shared types and constants for the instruction issue unit (MIPS R-format fields, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_issue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [5:0] OPC_HALT  = 6'b111111;
  localparam logic [5:0] OPC_RTYPE = 6'b000000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  // sll $0,$0,0 -- the canonical MIPS NOP
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // R-format field bit positions
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FN_MSB    = 5;
  localparam int FN_LSB    = 0;

  function automatic logic [5:0] get_opcode(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_buffer.sv
// Instruction store: DEPTH x 32 array, synchronous write, combinational read.
// Latency: write visible on the read port the cycle after wr_en; read is same-cycle.
// Backpressure: none; writes are always accepted when wr_en is high.
module instr_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  // Contents are deliberately not reset; the loader owns initialisation.
  logic [31:0] mem [DEPTH];

  // Array write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_issue_unit.sv
// Issues buffered MIPS R-format words one at a time, split into fields, to Main_CU (SKIP_NOP_EN drops all-zero words in FETCH).
// Latency: first issue_valid 2 cycles after start; sustained one instruction per 2 cycles.
// Backpressure: fields and pc hold while issue_valid && !issue_ready; loads/starts only honoured in IDLE or HALT.
module instr_issue_unit
  import instr_issue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          start,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [5:0]    opcode,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    shamt,
  output logic [5:0]    fn_code,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted
);

  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [31:0]   rd_data;
  logic          buf_we;
  logic          skip_nop;
  logic          at_last;

  // The buffer is only writable while the issue engine is parked.
  assign buf_we = ld_en && ((state_q == IDLE) || (state_q == HALT));

  instr_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (pc_q),
    .rd_data (rd_data)
  );

`ifdef SKIP_NOP_EN
  assign skip_nop = (rd_data == NOP_WORD);
`else
  assign skip_nop = 1'b0;
`endif

  assign at_last = (pc_q == PC_LAST);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Next-state, pc advance and field capture
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      IDLE, HALT: begin
        valid_d = 1'b0;
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (skip_nop) begin
          // A skipped word at the last entry still ends the run; no wrap.
          if (at_last) begin
            state_d = HALT;
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end else begin
          instr_d = rd_data;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (valid_q && issue_ready) begin
          valid_d = 1'b0;
          // The HALT word itself is issued, then the run ends.
          if ((get_opcode(instr_q) == OPC_HALT) || at_last) begin
            state_d = HALT;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign issue_valid = valid_q;
  assign opcode      = instr_q[OPC_MSB:OPC_LSB];
  assign rs          = instr_q[RS_MSB:RS_LSB];
  assign rt          = instr_q[RT_MSB:RT_LSB];
  assign rd          = instr_q[RD_MSB:RD_LSB];
  assign shamt       = instr_q[SHAMT_MSB:SHAMT_LSB];
  assign fn_code     = instr_q[FN_MSB:FN_LSB];
  assign pc          = pc_q;
  assign busy        = (state_q == FETCH) || (state_q == ISSUE);
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit: hand-computed expected fields, pc and status.
// Latency: checks the 2-cycle start-to-valid and the 2-cycle issue cadence.
// Backpressure: exercises held issue_ready=0 and reset during a pending handshake.
module tb_instr_issue_unit;
  import instr_issue_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  localparam logic [31:0] W_ADD  = 32'h0022_1820;
  localparam logic [31:0] W_SUB  = 32'h0022_1822;
  localparam logic [31:0] W_AND  = 32'h0022_1824;
  localparam logic [31:0] W_OR   = 32'h0022_1825;
  localparam logic [31:0] W_SRL  = 32'h0001_1042;
  localparam logic [31:0] W_HALT = 32'hFC00_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          start;
  logic          issue_valid;
  logic          issue_ready;
  logic [5:0]    opcode;
  logic [4:0]    rs, rt, rd, shamt;
  logic [5:0]    fn_code;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;

  int n_cmp = 0;
  int n_bad = 0;

  instr_issue_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .start       (start),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .fn_code     (fn_code),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] word_out();
    return {opcode, rs, rt, rd, shamt, fn_code};
  endfunction

  // Wait (bounded) for a presented instruction, check it, then step past the edge.
  task automatic expect_issue(input string tag, input int exp_pc, input logic [31:0] exp_w);
    int n = 0;
    while (!issue_valid && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, {31'd0, issue_valid}, 32'd1);
    chk({tag, "_pc"}, {28'd0, pc}, exp_pc);
    chk({tag, "_word"}, word_out(), exp_w);
    tick();
  endtask

  task automatic expect_halted(input string tag, input int exp_pc);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd1);
    chk({tag, "_vld"}, {31'd0, issue_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_pc"}, {28'd0, pc}, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; issue_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_vld",    {31'd0, issue_valid}, 32'd0);
    chk("rst_pc",     {28'd0, pc}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_word",   word_out(), 32'd0);

    // add, sub, halt with ready held high
    load(0, W_ADD); load(1, W_SUB); load(2, W_HALT);
    issue_ready = 1'b1;
    do_start();
    chk("t1_fetch_busy", {31'd0, busy}, 32'd1);
    chk("t1_fetch_vld",  {31'd0, issue_valid}, 32'd0);
    tick();
    chk("t1_lat2_vld", {31'd0, issue_valid}, 32'd1);
    chk("t1_fn_add",   {26'd0, fn_code}, {26'd0, FN_ADD});
    chk("t1_rd",       {27'd0, rd}, 32'd3);
    expect_issue("t1_add", 0, W_ADD);
    chk("t1_gap_vld", {31'd0, issue_valid}, 32'd0);
    expect_issue("t1_sub", 1, W_SUB);
    chk("t1_fn_sub", {26'd0, fn_code}, {26'd0, FN_SUB});
    expect_issue("t1_halt", 2, W_HALT);
    expect_halted("t1_end", 2);
    chk("t1_hold_opc", {26'd0, opcode}, {26'd0, OPC_HALT});

    // Backpressure: ready low for 3 cycles on the first word
    issue_ready = 1'b0;
    do_start();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_stall%0d_vld", i), {31'd0, issue_valid}, 32'd1);
      chk($sformatf("t2_stall%0d_pc", i), {28'd0, pc}, 32'd0);
      chk($sformatf("t2_stall%0d_word", i), word_out(), W_ADD);
      tick();
    end
    issue_ready = 1'b1;
    expect_issue("t2_add", 0, W_ADD);
    expect_issue("t2_sub", 1, W_SUB);
    expect_issue("t2_halt", 2, W_HALT);
    expect_halted("t2_end", 2);

    // Reset while the halt word at pc=2 is pending
    do_start();
    expect_issue("t4_add", 0, W_ADD);
    expect_issue("t4_sub", 1, W_SUB);
    issue_ready = 1'b0;
    tick();
    chk("t4_pend_vld", {31'd0, issue_valid}, 32'd1);
    chk("t4_pend_pc",  {28'd0, pc}, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_rst_vld",    {31'd0, issue_valid}, 32'd0);
    chk("t4_rst_pc",     {28'd0, pc}, 32'd0);
    chk("t4_rst_busy",   {31'd0, busy}, 32'd0);
    chk("t4_rst_halted", {31'd0, halted}, 32'd0);
    issue_ready = 1'b1;
    do_start();
    expect_issue("t4_re_add", 0, W_ADD);
    expect_issue("t4_re_sub", 1, W_SUB);
    expect_issue("t4_re_halt", 2, W_HALT);
    expect_halted("t4_end", 2);

    // Load while busy is dropped; load in HALT lands; load+start same cycle
    issue_ready = 1'b0;
    do_start();
    chk("t5_busy", {31'd0, busy}, 32'd1);
    load(1, W_SRL);
    issue_ready = 1'b1;
    expect_issue("t5_add", 0, W_ADD);
    expect_issue("t5_sub_kept", 1, W_SUB);
    expect_issue("t5_halt", 2, W_HALT);
    expect_halted("t5_end", 2);
    load(1, W_SRL);
    ld_en = 1'b1; ld_addr = 0; ld_data = W_AND; start = 1'b1;
    tick();
    ld_en = 1'b0; start = 1'b0;
    expect_issue("t5_and_first", 0, W_AND);
    chk("t5_pc_srl", {28'd0, pc}, 32'd1);
    expect_issue("t5_srl", 1, W_SRL);
    chk("t5_fn_srl", {26'd0, fn_code}, {26'd0, FN_SRL});
    expect_issue("t5_halt2", 2, W_HALT);
    expect_halted("t5_end2", 2);

    // Fill every entry with and/or: 16 issues, stop at pc=15, no wrap
    for (int i = 0; i < DEPTH; i++) load(AW'(i), (i % 2 == 0) ? W_AND : W_OR);
    do_start();
    for (int i = 0; i < DEPTH; i++)
      expect_issue($sformatf("t3_e%0d", i), i, (i % 2 == 0) ? W_AND : W_OR);
    expect_halted("t3_end", DEPTH - 1);
    tick(); tick();
    chk("t3_nowrap_pc",  {28'd0, pc}, DEPTH - 1);
    chk("t3_nowrap_vld", {31'd0, issue_valid}, 32'd0);

    // NOP handling: buffer {0, 0, add, halt}
    load(0, NOP_WORD); load(1, NOP_WORD); load(2, W_ADD); load(3, W_HALT);
    do_start();
`ifdef SKIP_NOP_EN
    expect_issue("t6_add", 2, W_ADD);
    chk("t6_fn_add", {26'd0, fn_code}, {26'd0, FN_ADD});
`else
    expect_issue("t6_nop0", 0, NOP_WORD);
    chk("t6_nop0_opc", {26'd0, opcode}, {26'd0, OPC_RTYPE});
    expect_issue("t6_nop1", 1, NOP_WORD);
    chk("t6_nop1_fn", {26'd0, fn_code}, {26'd0, FN_SLL});
    expect_issue("t6_add", 2, W_ADD);
`endif
    expect_issue("t6_halt", 3, W_HALT);
    expect_halted("t6_end", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
